axi_rd_arbiter: RTL and testbench

//  Shares the core's single AXI4 read master (AR/R channels) between two requesters: req0 = instruction fetch, req1 = data load.
//  One burst outstanding at a time. Round-robin grant, registered AR issue, R beats steered to the owning requester.
//  Per-burst beat counting against arlen; an error pulse flags protocol or response faults.

---
 rtl/axi_rd_arbiter.sv | 129 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between fetch (req0) and load (req1).
// One burst in flight; AR is registered, R beats are steered to the owner and counted against arlen.
module axi_rd_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 64,
  parameter logic [2:0]  ARSIZE_V  = 3'd3,
  parameter logic [1:0]  ARBURST_V = 2'b01,
  parameter logic [3:0]  ARCACHE_V = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_len,
  output logic              req1_ready,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rd_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arcache,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  output logic              rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              grant_vld;
  logic              grant_id;

  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arvalid  = (state_q == ADDR);
  assign arsize   = ARSIZE_V;
  assign arburst  = ARBURST_V;
  assign arcache  = ARCACHE_V;
  assign rsp_data = rdata;
  assign rsp_last = rlast;

  // On a tie the requester that did not win last time gets the grant.
  assign grant_vld = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rready       = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rd_err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          araddr_d     = grant_id ? req1_addr : req0_addr;
          arlen_d      = grant_id ? req1_len : req0_len;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          beat_cnt_d   = 8'd0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (arready) state_d = DATA;
      end
      DATA: begin
        rready     = owner_q ? rsp1_ready : rsp0_ready;
        rsp0_valid = rvalid & ~owner_q;
        rsp1_valid = rvalid & owner_q;
        if (rvalid && rready) begin
          if (beat_cnt_q != 8'hff) beat_cnt_d = beat_cnt_q + 8'd1;
          // beat_cnt_q is the zero-based index of this beat, so the final beat must equal arlen.
          rd_err = (rresp != 2'b00)
                 | (rlast & (beat_cnt_q != arlen_q))
                 | (~rlast & (beat_cnt_q == arlen_q));
          if (rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arlen_q      <= 8'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: per-cycle vector table plus hand-written arbitration and stall sequences.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_addr, req1_addr, araddr;
  logic [7:0]  req0_len, req1_len, arlen;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp_data, rdata;
  logic        rsp_last, rd_err, arvalid, arready, rvalid, rlast, rready;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rd_err(rd_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arcache(arcache),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
  );

  typedef struct {
    logic        rst, r0v;
    logic [31:0] r0a;
    logic [7:0]  r0l;
    logic        r1v;
    logic [31:0] r1a;
    logic [7:0]  r1l;
    logic        p0r, p1r, arr, rv;
    logic [63:0] rd;
    logic [1:0]  rr;
    logic        rl;
    logic        e_r0rdy, e_r1rdy, e_arv;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic        e_rrdy, e_p0v, e_p1v, e_err;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];
  vec_t v;
  logic [63:0] got_q[$];
  int          grants_q[$];
  logic        prev_rdy, cur_rdy;
  int          last_gid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req0_addr = 0; req0_len = 0;
    req1_valid = 0; req1_addr = 0; req1_len = 0;
    rsp0_ready = 0; rsp1_ready = 0; arready = 0;
    rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst r0v r0a     r0l r1v r1a     r1l p0r p1r arr rv rd     rr rl  r0y r1y arv addr    len rrdy p0v p1v err
    vt[0]  = '{1, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 0, 0,       0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 'h1000,  3, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  1, 0, 0, 0,       0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 1, 'h1000,  3, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 1, 'h1000,  3, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 1, 0, 0,     0, 0,  0, 0, 1, 'h1000,  3, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 1, 'hA0,  0, 0,  0, 0, 0, 'h1000,  3, 1, 1, 0, 0};
    vt[6]  = '{0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 1, 'hA1,  0, 0,  0, 0, 0, 'h1000,  3, 1, 1, 0, 0};
    vt[7]  = '{0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 1, 'hA2,  0, 0,  0, 0, 0, 'h1000,  3, 1, 1, 0, 0};
    vt[8]  = '{0, 0, 0,       0, 0, 0,       0, 1, 0, 0, 1, 'hA3,  0, 1,  0, 0, 0, 'h1000,  3, 1, 1, 0, 0};
    vt[9]  = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 0, 'h1000,  3, 0, 0, 0, 0};
    vt[10] = '{0, 0, 0,       0, 1, 'h2000,  3, 0, 0, 0, 0, 0,     0, 0,  0, 1, 0, 'h1000,  3, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 1, 0, 0,     0, 0,  0, 0, 1, 'h2000,  3, 0, 0, 0, 0};
    vt[12] = '{0, 0, 0,       0, 0, 0,       0, 0, 1, 0, 1, 'hB0,  2, 0,  0, 0, 0, 'h2000,  3, 1, 0, 1, 1};
    vt[13] = '{0, 0, 0,       0, 0, 0,       0, 0, 1, 0, 1, 'hB1,  0, 1,  0, 0, 0, 'h2000,  3, 1, 0, 1, 1};
    vt[14] = '{0, 0, 0,       0, 0, 0,       0, 0, 1, 0, 1, 'hB2,  0, 1,  0, 0, 0, 'h2000,  3, 0, 0, 0, 0};
    vt[15] = '{0, 1, 'h3000,  0, 1, 'h4000,  0, 0, 0, 0, 0, 0,     0, 0,  1, 0, 0, 'h2000,  3, 0, 0, 0, 0};
    vt[16] = '{0, 0, 0,       0, 1, 'h4000,  0, 0, 0, 1, 0, 0,     0, 0,  0, 0, 1, 'h3000,  0, 0, 0, 0, 0};
    vt[17] = '{0, 0, 0,       0, 1, 'h4000,  0, 1, 0, 0, 1, 'hC0,  0, 0,  0, 0, 0, 'h3000,  0, 1, 1, 0, 1};
    vt[18] = '{0, 0, 0,       0, 1, 'h4000,  0, 1, 0, 0, 1, 'hC1,  0, 0,  0, 0, 0, 'h3000,  0, 1, 1, 0, 0};
    vt[19] = '{0, 0, 0,       0, 1, 'h4000,  0, 1, 0, 0, 1, 'hC2,  0, 1,  0, 0, 0, 'h3000,  0, 1, 1, 0, 1};
    vt[20] = '{0, 0, 0,       0, 1, 'h4000,  0, 0, 0, 0, 0, 0,     0, 0,  0, 1, 0, 'h3000,  0, 0, 0, 0, 0};
    vt[21] = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 1, 'h4000,  0, 0, 0, 0, 0};
    vt[22] = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 1, 0, 0,     0, 0,  0, 0, 1, 'h4000,  0, 0, 0, 0, 0};
    vt[23] = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 1, 'hD0,  0, 0,  0, 0, 0, 'h4000,  0, 0, 0, 1, 0};
    vt[24] = '{1, 1, 'h5000,  2, 0, 0,       0, 0, 1, 0, 1, 'hD0,  0, 1,  0, 0, 0, 'h4000,  0, 1, 0, 1, 0};
    vt[25] = '{0, 1, 'h5000,  2, 0, 0,       0, 0, 1, 0, 1, 'hD0,  0, 1,  1, 0, 0, 0,       0, 0, 0, 0, 0};
    vt[26] = '{0, 0, 0,       0, 0, 0,       0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 1, 'h5000,  2, 0, 0, 0, 0};

    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);

    // Each row: inputs applied on the falling edge, outputs compared 1 ns later, state advances at the next rising edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      v = vt[i];
      rst = v.rst;
      req0_valid = v.r0v; req0_addr = v.r0a; req0_len = v.r0l;
      req1_valid = v.r1v; req1_addr = v.r1a; req1_len = v.r1l;
      rsp0_ready = v.p0r; rsp1_ready = v.p1r; arready = v.arr;
      rvalid = v.rv; rdata = v.rd; rresp = v.rr; rlast = v.rl;
      #1;
      chk($sformatf("row%0d req0_ready", i), req0_ready, v.e_r0rdy);
      chk($sformatf("row%0d req1_ready", i), req1_ready, v.e_r1rdy);
      chk($sformatf("row%0d arvalid", i), arvalid, v.e_arv);
      chk($sformatf("row%0d araddr", i), araddr, v.e_addr);
      chk($sformatf("row%0d arlen", i), arlen, v.e_len);
      chk($sformatf("row%0d rready", i), rready, v.e_rrdy);
      chk($sformatf("row%0d rsp0_valid", i), rsp0_valid, v.e_p0v);
      chk($sformatf("row%0d rsp1_valid", i), rsp1_valid, v.e_p1v);
      chk($sformatf("row%0d rd_err", i), rd_err, v.e_err);
    end
    chk("arsize", arsize, 3'd3);
    chk("arburst", arburst, 2'b01);
    chk("arcache", arcache, 4'b0011);

    // Both requesters valid continuously with single-beat bursts: grants must alternate.
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(negedge clk);
    rst = 0;
    req0_valid = 1; req0_addr = 'h100; req0_len = 0;
    req1_valid = 1; req1_addr = 'h200; req1_len = 0;
    arready = 1; rvalid = 1; rlast = 1; rdata = 'h55;
    rsp0_ready = 1; rsp1_ready = 1;
    prev_rdy = 0;
    last_gid = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      cur_rdy = req0_ready | req1_ready;
      chk($sformatf("rr c%0d both_ready", c), req0_ready & req1_ready, 1'b0);
      chk($sformatf("rr c%0d ready_twice", c), prev_rdy & cur_rdy, 1'b0);
      chk($sformatf("rr c%0d rd_err", c), rd_err, 1'b0);
      if (req0_ready) begin grants_q.push_back(0); last_gid = 0; end
      if (req1_ready) begin grants_q.push_back(1); last_gid = 1; end
      if (arvalid) chk($sformatf("rr c%0d araddr", c), araddr, (last_gid == 1) ? 64'h200 : 64'h100);
      prev_rdy = cur_rdy;
      @(negedge clk);
    end
    chk("rr grant_count", grants_q.size(), 4);
    for (int g = 0; g < 4; g++) begin
      if (g < grants_q.size()) chk($sformatf("rr grant%0d", g), grants_q[g], g % 2);
    end

    // Load burst of two beats with the load side stalling for three cycles.
    rst = 1;
    clear_inputs();
    @(negedge clk);
    rst = 0;
    req1_valid = 1; req1_addr = 'h600; req1_len = 1;
    arready = 1;
    #1;
    chk("stall req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("stall arvalid", arvalid, 1'b1);
    @(negedge clk);
    rvalid = 1; rdata = 64'hDEAD_0000_0000_0000; rlast = 0; rsp1_ready = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("stall s%0d rready", s), rready, 1'b0);
      chk($sformatf("stall s%0d rsp1_valid", s), rsp1_valid, 1'b1);
      chk($sformatf("stall s%0d rsp_data", s), rsp_data, 64'hDEAD_0000_0000_0000);
      @(negedge clk);
    end
    rsp1_ready = 1;
    #1;
    chk("stall beat0 rready", rready, 1'b1);
    chk("stall beat0 rsp_last", rsp_last, 1'b0);
    chk("stall beat0 rd_err", rd_err, 1'b0);
    if (rready && rvalid) got_q.push_back(rsp_data);
    @(negedge clk);
    rdata = 64'hBEEF_0000_0000_0001; rlast = 1;
    #1;
    chk("stall beat1 rsp_last", rsp_last, 1'b1);
    chk("stall beat1 rd_err", rd_err, 1'b0);
    if (rready && rvalid) got_q.push_back(rsp_data);
    @(negedge clk);
    rvalid = 0; rlast = 0;
    #1;
    chk("stall end rready", rready, 1'b0);
    chk("stall end arvalid", arvalid, 1'b0);
    chk("stall beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("stall data0", got_q[0], 64'hDEAD_0000_0000_0000);
      chk("stall data1", got_q[1], 64'hBEEF_0000_0000_0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
